// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Multiplexed seven-segment display driver for common-anode digits. A frame
// of per-digit active-low segment codes plus decimal points is captured into
// a pending buffer on load. It moves into the display register only at a
// frame boundary, so a scanned frame never mixes old and new digits. Each
// digit slot starts with a blanked gap to suppress ghosting. Leading zeros
// can optionally be blanked.
//
// Parameters
//   N_DIGITS     : digits scanned (1..8)
//   SCAN_DIV     : clock cycles per digit slot (>= 2)
//   BLANK_CYCLES : blanked cycles at the start of each slot (< SCAN_DIV)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   codes_in   in   7*N_DIGITS segment codes, digit i at [7i+6:7i], gfedcba
//                   active-low, digit N_DIGITS-1 most significant
//   dp_in      in   N_DIGITS decimal point enables, active-high
//   load       in   capture codes_in/dp_in into the pending buffer
//   lz_blank   in   leading-zero blanking enable
//   load_ack   out  one-cycle pulse when the pending frame is displayed
//   frame_tick out  one-cycle pulse on the last cycle of each full scan
//   seg        out  active-low segment pins
//   dp_n       out  active-low decimal point pin
//   an         out  N_DIGITS active-low anode enables
// ---------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7*N_DIGITS-1:0]   codes_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic                    load_ack,
    output logic                    frame_tick,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an
);

    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CYC   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM  = CW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_OFF    = 7'h7F;
    localparam logic [6:0]    SEG_ZERO   = 7'b1000000;

    typedef enum logic {
        PH_BLANK,
        PH_ACTIVE
    } phase_t;

    // Pending buffer and display register
    logic [N_DIGITS-1:0][6:0] pend_codes;
    logic [N_DIGITS-1:0]      pend_dp;
    logic                     pend_valid;
    logic [N_DIGITS-1:0][6:0] disp_codes;
    logic [N_DIGITS-1:0]      disp_dp;

    // Scan counters
    logic [DW-1:0] digit;
    logic [CW-1:0] cyc;

    // Combinational next-output values
    logic                boundary;
    logic                transfer;
    phase_t              phase;
    logic [N_DIGITS-1:0] lz_mask;
    logic [N_DIGITS-1:0] an_next;
    logic [6:0]          seg_next;
    logic                dp_n_next;

    assign boundary = (digit == LAST_DIGIT) && (cyc == LAST_CYC);
    // The transfer decision uses pend_valid as it stood before this cycle's
    // capture, so a load on the boundary cycle waits for the next frame.
    assign transfer = boundary && pend_valid;

    // A digit is a leading zero when it and every more significant digit
    // show a plain zero with no decimal point. Digit 0 always displays.
    always_comb begin
        logic run;
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        lz_mask = '0;
        run     = lz_blank;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run = run && (disp_codes[i] == SEG_ZERO) && !disp_dp[i];
            if (i > 0) lz_mask[i] = run;
        end
    end

    always_comb begin
        phase     = (cyc < BLANK_LIM) ? PH_BLANK : PH_ACTIVE;
        an_next   = '1;
        seg_next  = SEG_OFF;
        dp_n_next = 1'b1;
        if (phase == PH_ACTIVE) begin
            an_next[digit] = 1'b0;
            seg_next       = lz_mask[digit] ? SEG_OFF : disp_codes[digit];
            dp_n_next      = ~disp_dp[digit];
        end
    end

    // Scan counters: cyc walks the slot, digit advances on each slot wrap.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc   <= '0;
            digit <= '0;
        end else if (cyc == LAST_CYC) begin
            cyc   <= '0;
            digit <= (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
        end else begin
            cyc   <= cyc + 1'b1;
        end
    end

    // Pending buffer: latest load wins; a capture on the boundary cycle
    // re-arms pend_valid after the transfer has consumed the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_codes <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (transfer) pend_valid <= 1'b0;
            if (load) begin
                pend_codes <= codes_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
        end
    end

    // Display register: reset to a dark display so nothing flashes before
    // the first frame is loaded.
    // NOTE: this storage is reset explicitly because its contents reach the
    // pins; it is small enough to live in flops rather than a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_codes <= {N_DIGITS{SEG_OFF}};
            disp_dp    <= '0;
        end else if (transfer) begin
            disp_codes <= pend_codes;
            disp_dp    <= pend_dp;
        end
    end

    // Registered pins, one cycle behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp_n       <= dp_n_next;
            load_ack   <= transfer;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Self-checking bench for seg_scan_driver with N_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2. Frame vectors hold the loaded codes and the hand-derived
// per-digit segment and decimal-point pins expected in the following frame.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BC = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7*N-1:0]    codes_in = '0;
    logic [N-1:0]      dp_in = '0;
    logic              load = 1'b0;
    logic              lz_blank = 1'b0;
    logic              load_ack;
    logic              frame_tick;
    logic [6:0]        seg;
    logic              dp_n;
    logic [N-1:0]      an;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_driver #(
        .N_DIGITS    (N),
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .codes_in  (codes_in),
        .dp_in     (dp_in),
        .load      (load),
        .lz_blank  (lz_blank),
        .load_ack  (load_ack),
        .frame_tick(frame_tick),
        .seg       (seg),
        .dp_n      (dp_n),
        .an        (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0][6:0] codes;    // [3] is the most significant digit
        logic [N-1:0]      dp;
        logic              lz;
        logic [N-1:0][6:0] exp_seg;  // seg during each digit's active window
        logic [N-1:0]      exp_dpn;  // dp_n during each digit's active window
        string             name;
    } vec_t;

    function automatic vec_t mk(input logic [27:0] codes, input logic [3:0] dp,
                                input logic lz, input logic [27:0] es,
                                input logic [3:0] edn, input string name);
        vec_t v;
        v.codes   = codes;
        v.dp      = dp;
        v.lz      = lz;
        v.exp_seg = es;
        v.exp_dpn = edn;
        v.name    = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one load pulse starting at the current negedge.
    task automatic load_vec(input vec_t v);
        codes_in = v.codes;
        dp_in    = v.dp;
        lz_blank = v.lz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Wait (bounded) for the next frame_tick; check the ack on that cycle and
    // that no ack appears on any other cycle.
    task automatic wait_tick(input logic exp_ack, input string tag);
        bit   seen = 0;
        int   stray = 0;
        logic ack_at_tick = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (frame_tick) begin
                seen        = 1;
                ack_at_tick = load_ack;
            end else if (load_ack) begin
                stray++;
            end
        end
        check({tag, " tick seen"}, 32'(seen), 32'd1);
        check({tag, " ack at tick"}, 32'(ack_at_tick), 32'(exp_ack));
        check({tag, " stray acks"}, stray, 0);
    endtask

    // Starting right after a frame_tick (or reset release), check every
    // cycle of one full frame. The last cycle is the next frame_tick.
    task automatic check_frame(input vec_t v);
        logic [3:0] one = 4'b0001;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dpn;
        logic       e_tick;
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < SD; c++) begin
                @(negedge clk);
                if (c < BC) begin
                    e_an  = 4'hF;
                    e_seg = 7'h7F;
                    e_dpn = 1'b1;
                end else begin
                    e_an  = ~(one << d);
                    e_seg = v.exp_seg[d];
                    e_dpn = v.exp_dpn[d];
                end
                e_tick = (d == N - 1) && (c == SD - 1);
                check($sformatf("%s d%0d c%0d {an,seg,dp_n,tick,ack}", v.name, d, c),
                      {18'b0, an, seg, dp_n, frame_tick, load_ack},
                      {18'b0, e_an, e_seg, e_dpn, e_tick, 1'b0});
            end
        end
    endtask

    vec_t vecs[5];
    vec_t v_dark, v_1234, v_5678;

    initial begin
        // Segment codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00
        v_dark = mk({4{7'h7F}}, 4'b0000, 1'b0, {4{7'h7F}}, 4'hF, "dark");
        v_1234 = mk({7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, 1'b0,
                    {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, "1234");
        v_5678 = mk({7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000, 1'b0,
                    {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, "5678");
        vecs[0] = v_1234;
        vecs[1] = mk({7'h40, 7'h40, 7'h40, 7'h78}, 4'b0000, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF, "lz_0007");
        vecs[2] = mk({4{7'h40}}, 4'b0000, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, "lz_0000");
        vecs[3] = mk({4{7'h40}}, 4'b0000, 1'b0,
                     {4{7'h40}}, 4'hF, "nolz_0000");
        vecs[4] = mk({7'h40, 7'h40, 7'h40, 7'h79}, 4'b0100, 1'b1,
                     {7'h7F, 7'h40, 7'h40, 7'h79}, 4'b1011, "dp_0001");

        // Reset state
        repeat (3) @(negedge clk);
        check("reset {an,seg,dp_n,ack,tick}",
              {18'b0, an, seg, dp_n, load_ack, frame_tick},
              {18'b0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;
        check_frame(v_dark);

        // Table-driven frames: load mid-frame, ack at next boundary, then
        // the whole following frame shows the new contents.
        for (int i = 0; i < 5; i++) begin
            load_vec(vecs[i]);
            wait_tick(1'b1, vecs[i].name);
            check_frame(vecs[i]);
        end

        // Double load in one frame: single ack, only the last one shown.
        load_vec(v_1234);
        repeat (5) @(negedge clk);
        load_vec(v_5678);
        wait_tick(1'b1, "double");
        check_frame(v_5678);

        // Load exactly on the boundary cycle with nothing pending.
        repeat (SD * N - 1) @(negedge clk);
        codes_in = v_1234.codes;
        dp_in    = v_1234.dp;
        lz_blank = v_1234.lz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        check("bnd tick", 32'(frame_tick), 32'd1);
        check("bnd no ack", 32'(load_ack), 32'd0);
        wait_tick(1'b1, "bnd next");
        check_frame(v_1234);

        // Asynchronous reset in the middle of digit 2's active window.
        repeat (2 * SD + 5) @(negedge clk);
        check("pre-reset an", 32'(an), 32'(4'b1011));
        #1 rst_n = 1'b0;
        #1;
        check("async reset {an,seg,dp_n}", {20'b0, an, seg, dp_n},
              {20'b0, 4'hF, 7'h7F, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(v_dark);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
